// File: rtl/icache_direct_pkg.sv
// Shared cache geometry defaults and refill FSM state encodings for icache_direct.
package icache_direct_pkg;

  localparam int ICACHE_LINES          = 16;
  localparam int ICACHE_WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {
    ICACHE_S_IDLE      = 2'd0,
    ICACHE_S_REQ       = 2'd1,
    ICACHE_S_WAIT      = 2'd2,
    ICACHE_S_FILL_DONE = 2'd3
  } icache_state_e;

endpackage

// File: rtl/icache_data_array.sv
// Tag, data and valid storage for icache_direct: asynchronous read port,
// single refill write port, bulk invalidate. Only the valid bits are reset.
module icache_data_array
  import icache_direct_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int LINES          = ICACHE_LINES,
  parameter int WORDS_PER_LINE = ICACHE_WORDS_PER_LINE,
  parameter int TAG_W          = 26
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [$clog2(LINES)-1:0]          rd_idx,
  input  logic [$clog2(WORDS_PER_LINE)-1:0] rd_off,
  output logic                              rd_valid,
  output logic [TAG_W-1:0]                  rd_tag,
  output logic [XLEN-1:0]                   rd_data,
  input  logic                              wr_en,
  input  logic [$clog2(LINES)-1:0]          wr_idx,
  input  logic [$clog2(WORDS_PER_LINE)-1:0] wr_off,
  input  logic [XLEN-1:0]                   wr_data,
  input  logic                              set_valid,
  input  logic [TAG_W-1:0]                  set_tag,
  input  logic                              inv_all
);

  logic [XLEN-1:0]  data_mem [LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [LINES-1:0] valid_r;

  assign rd_valid = valid_r[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[{rd_idx, rd_off}];

  // Refill writes into the data and tag arrays (not reset)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[{wr_idx, wr_off}] <= wr_data;
    end
    if (set_valid) begin
      tag_mem[wr_idx] <= set_tag;
    end
  end

  // Valid bits: invalidate-all takes priority over a completing fill
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= {LINES{1'b0}};
    end else if (inv_all) begin
      valid_r <= {LINES{1'b0}};
    end else if (set_valid) begin
      valid_r[wr_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with line refill FSM.
// Optional ICACHE_PERF_CNT_EN adds wrapping hit_count/miss_count outputs.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int LINES          = ICACHE_LINES,
  parameter int WORDS_PER_LINE = ICACHE_WORDS_PER_LINE
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [XLEN-1:0] req_addr,
  input  logic            flush,
  output logic [XLEN-1:0] rsp_instr,
  output logic            rsp_valid,
  output logic            icache_stall,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
`endif
);

  localparam int WO    = $clog2(WORDS_PER_LINE);
  localparam int IW    = $clog2(LINES);
  localparam int TAG_W = XLEN - 2 - WO - IW;
  localparam logic [WO-1:0] LAST_BEAT = WO'(WORDS_PER_LINE - 1);
  localparam logic [WO-1:0] BEAT_ONE  = WO'(1);

  icache_state_e    state_r, state_nxt_s;
  logic [WO-1:0]    beat_r;
  logic [TAG_W-1:0] line_tag_r;
  logic [IW-1:0]    line_idx_r;
  logic             drop_r;

  logic [WO-1:0]    req_off_s;
  logic [IW-1:0]    req_idx_s;
  logic [TAG_W-1:0] req_tag_s;
  logic             rd_valid_s;
  logic [TAG_W-1:0] rd_tag_s;
  logic [XLEN-1:0]  rd_data_s;
  logic             hit_s, start_s, fill_beat_s, last_beat_s, set_valid_s;
  logic             addr_unused_s;

  assign req_off_s     = req_addr[2 +: WO];
  assign req_idx_s     = req_addr[2 + WO +: IW];
  assign req_tag_s     = req_addr[XLEN-1 -: TAG_W];
  assign addr_unused_s = ^req_addr[1:0];

  assign hit_s = req_valid & rd_valid_s & (rd_tag_s == req_tag_s)
               & (state_r == ICACHE_S_IDLE) & ~flush;

  assign rsp_valid     = hit_s;
  assign rsp_instr     = rd_data_s;
  assign icache_stall  = req_valid & ~hit_s;
  assign mem_req_valid = (state_r == ICACHE_S_REQ);
  assign mem_req_addr  = {line_tag_r, line_idx_r, beat_r, 2'b00};

  // A flush anywhere in the refill (including its final beat) keeps the line invalid
  assign set_valid_s = last_beat_s & ~drop_r & ~flush;

  icache_data_array #(
    .XLEN           (XLEN),
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W          (TAG_W)
  ) u_array (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (req_idx_s),
    .rd_off    (req_off_s),
    .rd_valid  (rd_valid_s),
    .rd_tag    (rd_tag_s),
    .rd_data   (rd_data_s),
    .wr_en     (fill_beat_s),
    .wr_idx    (line_idx_r),
    .wr_off    (beat_r),
    .wr_data   (mem_rsp_data),
    .set_valid (set_valid_s),
    .set_tag   (line_tag_r),
    .inv_all   (flush)
  );

  // Refill FSM next-state and per-cycle strobes
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    fill_beat_s = 1'b0;
    last_beat_s = 1'b0;
    case (state_r)
      ICACHE_S_IDLE: begin
        if (req_valid && !hit_s) begin
          start_s     = 1'b1;
          state_nxt_s = ICACHE_S_REQ;
        end else begin
          state_nxt_s = ICACHE_S_IDLE;
        end
      end
      ICACHE_S_REQ: begin
        if (mem_req_ready) begin
          state_nxt_s = ICACHE_S_WAIT;
        end else begin
          state_nxt_s = ICACHE_S_REQ;
        end
      end
      ICACHE_S_WAIT: begin
        if (mem_rsp_valid) begin
          fill_beat_s = 1'b1;
          if (beat_r == LAST_BEAT) begin
            last_beat_s = 1'b1;
            state_nxt_s = ICACHE_S_FILL_DONE;
          end else begin
            state_nxt_s = ICACHE_S_REQ;
          end
        end else begin
          state_nxt_s = ICACHE_S_WAIT;
        end
      end
      ICACHE_S_FILL_DONE: state_nxt_s = ICACHE_S_IDLE;
      default:            state_nxt_s = ICACHE_S_IDLE;
    endcase
  end

  // FSM state, beat counter, latched line address and flush-drop flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ICACHE_S_IDLE;
      beat_r     <= {WO{1'b0}};
      line_tag_r <= {TAG_W{1'b0}};
      line_idx_r <= {IW{1'b0}};
      drop_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (start_s) begin
        beat_r     <= {WO{1'b0}};
        line_tag_r <= req_tag_s;
        line_idx_r <= req_idx_s;
        drop_r     <= 1'b0;
      end else begin
        if (fill_beat_s && !last_beat_s) begin
          beat_r <= beat_r + BEAT_ONE;
        end
        if (flush && (state_r == ICACHE_S_REQ || state_r == ICACHE_S_WAIT)) begin
          drop_r <= 1'b1;
        end
      end
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // Wrapping hit/miss counters, unaffected by flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (hit_s) begin
        hit_count <= hit_count + 32'd1;
      end
      if (start_s) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Directed self-checking bench for icache_direct with a 1-cycle-latency memory model.
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic        flush = 1'b0;
  logic [31:0] rsp_instr;
  logic        rsp_valid;
  logic        icache_stall;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] acc_q[$];
  logic [31:0] bp_addr = 32'h0;
  int          bp_left = 0;

  icache_direct dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .flush         (flush),
    .rsp_instr     (rsp_instr),
    .rsp_valid     (rsp_valid),
    .icache_stall  (icache_stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count     (hit_count),
    .miss_count    (miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Backing memory: word at address A is {16'hC0DE, A[15:0]}, returned one cycle after acceptance
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_rsp_valid <= 1'b0;
      mem_rsp_data  <= 32'h0;
    end else begin
      mem_rsp_valid <= mem_req_valid && mem_req_ready;
      mem_rsp_data  <= {16'hC0DE, mem_req_addr[15:0]};
      if (mem_req_valid && mem_req_ready) acc_q.push_back(mem_req_addr);
    end
  end

  // Ready driver: hold ready low for bp_left cycles while bp_addr is requested
  always @(negedge clk) begin
    if (bp_left > 0 && mem_req_valid && mem_req_addr == bp_addr) begin
      mem_req_ready = 1'b0;
      bp_left = bp_left - 1;
    end else begin
      mem_req_ready = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_hit(output int n);
    n = 0;
    while (!rsp_valid && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic check_line_beats(input string tag, input logic [31:0] base);
    logic [31:0] got;
    check_eq({tag, "_nbeats"}, acc_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      got = (acc_q.size() > i) ? acc_q[i] : 32'hFFFF_FFFF;
      check_eq({tag, "_beat_addr"}, got, base + 32'(4 * i));
    end
    acc_q.delete();
  endtask

  initial begin
    int n;
    int low;
    logic hit_seen;
    logic [31:0] got;

    req_valid = 1'b1;
    req_addr  = 32'h0000_0010;
    repeat (3) step();
    check_eq("rst_rsp_valid", rsp_valid, 32'd0);
    check_eq("rst_stall", icache_stall, 32'd1);
    check_eq("rst_mem_req_valid", mem_req_valid, 32'd0);

    // Cold miss on 0x10
    @(negedge clk);
    reset = 1'b1;
    #1;
    wait_hit(n);
    check_eq("cold_stall_cycles", n, 32'd10);
    check_eq("cold_instr", rsp_instr, 32'hC0DE_0010);
    check_line_beats("cold", 32'h0000_0010);

    // Hits on the rest of the line
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      req_addr = 32'h0000_0010 + 32'(4 * i);
      #1;
      check_eq("hit_rsp_valid", rsp_valid, 32'd1);
      check_eq("hit_stall", icache_stall, 32'd0);
      check_eq("hit_mem_req_valid", mem_req_valid, 32'd0);
      check_eq("hit_instr", rsp_instr, 32'hC0DE_0010 + 32'(4 * i));
    end
    check_eq("hit_no_beats", acc_q.size(), 32'd0);

    // Conflict: 0x110 shares index 1
    @(negedge clk);
    req_addr = 32'h0000_0110;
    #1;
    check_eq("conf_miss", rsp_valid, 32'd0);
    wait_hit(n);
    check_eq("conf_stall_cycles", n, 32'd10);
    check_eq("conf_instr", rsp_instr, 32'hC0DE_0110);
    check_line_beats("conf", 32'h0000_0110);

    // Re-access 0x10 misses; ready held low 3 cycles on beat 2
    @(negedge clk);
    bp_addr  = 32'h0000_0018;
    bp_left  = 3;
    req_addr = 32'h0000_0010;
    #1;
    check_eq("evict_miss", rsp_valid, 32'd0);
    n = 0;
    low = 0;
    while (!rsp_valid && n < 100) begin
      if (!mem_req_ready) begin
        low++;
        check_eq("bp_req_valid", mem_req_valid, 32'd1);
        check_eq("bp_req_addr", mem_req_addr, 32'h0000_0018);
      end
      n++;
      step();
    end
    check_eq("bp_low_cycles", low, 32'd3);
    check_eq("bp_stall_cycles", n, 32'd13);
    check_eq("bp_instr", rsp_instr, 32'hC0DE_0010);
    check_line_beats("bp", 32'h0000_0010);

    // Flush in IDLE forces a miss that cycle and the next
    @(negedge clk);
    flush = 1'b1;
    #1;
    check_eq("flush_idle_rsp", rsp_valid, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check_eq("flush_idle_after", rsp_valid, 32'd0);
    wait_hit(n);
    check_eq("flush_idle_stall", n, 32'd9);
    check_line_beats("flush_idle", 32'h0000_0010);

    // Flush during beat-1 WAIT of a fill to 0x40
    @(negedge clk);
    req_addr = 32'h0000_0040;
    #1;
    n = 0;
    while (!(acc_q.size() == 2 && !mem_req_valid) && n < 20) begin
      n++;
      step();
    end
    check_eq("fm_reach_wait1", (n < 20), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    n = 0;
    hit_seen = 1'b0;
    while (acc_q.size() < 5 && n < 60) begin
      hit_seen |= rsp_valid;
      n++;
      step();
    end
    check_eq("fm_no_hit", hit_seen, 32'd0);
    for (int i = 0; i < 5; i++) begin
      got = (acc_q.size() > i) ? acc_q[i] : 32'hFFFF_FFFF;
      check_eq("fm_beat_addr", got, (i == 4) ? 32'h0000_0040 : 32'h0000_0040 + 32'(4 * i));
    end
    wait_hit(n);
    check_eq("fm_refill_instr", rsp_instr, 32'hC0DE_0040);
    acc_q.delete();

    // Async reset while in WAIT of a fill to 0x50
    @(negedge clk);
    req_addr = 32'h0000_0050;
    #1;
    n = 0;
    while (!(acc_q.size() == 1 && !mem_req_valid) && n < 20) begin
      n++;
      step();
    end
    check_eq("ar_reach_wait", (n < 20), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("ar_wait_req_valid", mem_req_valid, 32'd0);
    check_eq("ar_wait_rsp_valid", rsp_valid, 32'd0);
    check_eq("ar_wait_stall", icache_stall, 32'd1);
    req_addr = 32'h0000_0040;
    repeat (2) step();
    @(negedge clk);
    acc_q.delete();
    reset = 1'b1;
    #1;
    check_eq("ar_line_miss", rsp_valid, 32'd0);
    wait_hit(n);
    check_eq("ar_refill_stall", n, 32'd10);
    check_eq("ar_refill_instr", rsp_instr, 32'hC0DE_0040);
    acc_q.delete();

    // Async reset while a request is held in REQ drops mem_req_valid immediately
    @(negedge clk);
    bp_addr  = 32'h0000_0060;
    bp_left  = 4;
    req_addr = 32'h0000_0060;
    #1;
    n = 0;
    while (!mem_req_valid && n < 10) begin
      n++;
      step();
    end
    check_eq("ar_req_seen", mem_req_valid, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("ar_req_valid_drop", mem_req_valid, 32'd0);
    bp_left = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

endmodule
